// File: rtl/rk_kbd_pkg.sv
// Shared types and constants for the PS/2-to-matrix keyboard block.
// Contents: decoder state enum, modifier bit indices, special scan codes,
// keymap entry/result types and the keymap table itself.
package rk_kbd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBrk,
    StExt,
    StExtBrk
  } kbd_state_e;

  // Modifier bit positions in mods / mod_n.
  localparam int unsigned ModShift = 0;
  localparam int unsigned ModCtrl  = 1;
  localparam int unsigned ModRus   = 2;

  localparam logic [7:0] CodeBrk     = 8'hF0;
  localparam logic [7:0] CodeExt     = 8'hE0;
  localparam logic [7:0] CodeBatOk   = 8'hAA;
  localparam logic [7:0] CodeBatFail = 8'hFC;
  localparam logic [7:0] CodeF12     = 8'h07;

  // Lookup result. For modifiers, col carries the modifier bit index.
  typedef struct packed {
    logic       hit;
    logic       is_mod;
    logic [2:0] col;
    logic [2:0] row;
  } key_loc_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
    logic       is_mod;
    logic [2:0] col;
    logic [2:0] row;
  } keymap_entry_t;

  localparam int unsigned NumEntries = 25;

  localparam keymap_entry_t KeyMap [NumEntries] = '{
    '{1'b0, 8'h1C, 1'b0, 3'd2, 3'd4},  // A
    '{1'b0, 8'h5A, 1'b0, 3'd1, 3'd2},  // Enter
    '{1'b0, 8'h29, 1'b0, 3'd7, 3'd7},  // Space
    '{1'b0, 8'h32, 1'b0, 3'd3, 3'd4},  // B
    '{1'b0, 8'h21, 1'b0, 3'd4, 3'd4},  // C
    '{1'b0, 8'h23, 1'b0, 3'd5, 3'd4},  // D
    '{1'b0, 8'h24, 1'b0, 3'd6, 3'd4},  // E
    '{1'b0, 8'h2B, 1'b0, 3'd7, 3'd4},  // F
    '{1'b0, 8'h16, 1'b0, 3'd1, 3'd3},  // 1
    '{1'b0, 8'h1E, 1'b0, 3'd2, 3'd3},  // 2
    '{1'b0, 8'h26, 1'b0, 3'd3, 3'd3},  // 3
    '{1'b0, 8'h25, 1'b0, 3'd4, 3'd3},  // 4
    '{1'b0, 8'h66, 1'b0, 3'd2, 3'd1},  // Backspace
    '{1'b0, 8'h76, 1'b0, 3'd0, 3'd0},  // Esc
    '{1'b0, 8'h0D, 1'b0, 3'd1, 3'd0},  // Tab
    '{1'b0, 8'h05, 1'b0, 3'd2, 3'd0},  // F1
    '{1'b1, 8'h75, 1'b0, 3'd0, 3'd5},  // Up
    '{1'b1, 8'h72, 1'b0, 3'd0, 3'd6},  // Down
    '{1'b1, 8'h6B, 1'b0, 3'd0, 3'd7},  // Left
    '{1'b1, 8'h74, 1'b0, 3'd0, 3'd4},  // Right
    '{1'b0, 8'h12, 1'b1, 3'(ModShift), 3'd0},  // L-Shift
    '{1'b0, 8'h59, 1'b1, 3'(ModShift), 3'd0},  // R-Shift
    '{1'b0, 8'h14, 1'b1, 3'(ModCtrl), 3'd0},   // L-Ctrl
    '{1'b1, 8'h14, 1'b1, 3'(ModCtrl), 3'd0},   // R-Ctrl
    '{1'b0, 8'h58, 1'b1, 3'(ModRus), 3'd0}     // CapsLock -> RUS/LAT
  };

endpackage

// File: rtl/rk_keymap.sv
// Combinational scan-code lookup: {ext, code} -> matrix position or modifier.
// Ports:
//   ext  - code was preceded by E0
//   code - scan-code byte
//   loc  - lookup result (hit=0 on unmapped codes)
module rk_keymap
  import rk_kbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output key_loc_t   loc
);

  always_comb begin
    loc = '0;
    for (int i = 0; i < int'(NumEntries); i++) begin
      if (KeyMap[i].ext == ext && KeyMap[i].code == code) begin
        loc.hit    = 1'b1;
        loc.is_mod = KeyMap[i].is_mod;
        loc.col    = KeyMap[i].col;
        loc.row    = KeyMap[i].row;
      end
    end
  end

endmodule

// File: rtl/rk_kbd_matrix.sv
// PS/2 set-2 scan codes -> 8x8 key matrix plus three modifier lines, scanned
// by the CPU through the parallel port.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   code_valid  - one-cycle strobe, code holds a new byte
//   code        - PS/2 set-2 byte
//   col_n       - active-low column select (several may be low)
//   row_n       - active-low row sense, combinational from col_n
//   mod_n       - active-low modifiers {RUS/LAT, CTRL, SHIFT}
//   reset_req   - one-cycle pulse after an F12 make
module rk_kbd_matrix
  import rk_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] code,
  input  logic [7:0] col_n,
  output logic [7:0] row_n,
  output logic [2:0] mod_n,
  output logic       reset_req
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  kbd_state_e      state_q, state_d;
  logic [63:0]     keys_q, keys_d;  // bit index = {col, row}
  logic [2:0]      mods_q, mods_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            reset_req_q, reset_req_d;
  logic            is_ext, is_break;
  logic [7:0]      rows_sel;
  key_loc_t        loc;

  assign is_ext   = (state_q == StExt) || (state_q == StExtBrk);
  assign is_break = (state_q == StBrk) || (state_q == StExtBrk);

  rk_keymap u_keymap (
    .ext  (is_ext),
    .code (code),
    .loc  (loc)
  );

  always_comb begin
    state_d     = state_q;
    keys_d      = keys_q;
    mods_d      = mods_q;
    cnt_d       = cnt_q;
    reset_req_d = 1'b0;
    if (code_valid) begin
      cnt_d = '0;
      if (code == CodeBrk) begin
        state_d = is_ext ? StExtBrk : StBrk;
      end else if (code == CodeExt) begin
        // E0 after F0 is ignored; repeated E0 keeps the extended prefix.
        if (state_q == StIdle) state_d = StExt;
      end else begin
        state_d = StIdle;
        if (state_q == StIdle && (code == CodeBatOk || code == CodeBatFail)) begin
          keys_d = '0;
          mods_d = '0;
        end else if (loc.hit) begin
          if (loc.is_mod) begin
            for (int m = 0; m < 3; m++) begin
              if (loc.col == 3'(m)) mods_d[m] = ~is_break;
            end
          end else begin
            keys_d[{loc.col, loc.row}] = ~is_break;
          end
        end
        if (state_q == StIdle && code == CodeF12) reset_req_d = 1'b1;
      end
    end else if (state_q != StIdle) begin
      // Drop a stale prefix TIMEOUT cycles after the last byte.
      if (cnt_q == CntW'(TIMEOUT - 1)) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      keys_q      <= '0;
      mods_q      <= '0;
      cnt_q       <= '0;
      reset_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      keys_q      <= keys_d;
      mods_q      <= mods_d;
      cnt_q       <= cnt_d;
      reset_req_q <= reset_req_d;
    end
  end

  always_comb begin
    rows_sel = '0;
    for (int c = 0; c < 8; c++) begin
      if (!col_n[c]) rows_sel = rows_sel | keys_q[c*8 +: 8];
    end
  end

  assign row_n     = ~rows_sel;
  assign mod_n     = ~mods_q;
  assign reset_req = reset_req_q;

endmodule

// File: tb/tb_rk_kbd_matrix.sv
// Bench for rk_kbd_matrix: directed cases plus random scan-code streams,
// checked through an expectation queue drained by a negedge monitor.
module tb_rk_kbd_matrix;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       code_valid;
  logic [7:0] code;
  logic [7:0] col_n;
  logic [7:0] row_n;
  logic [2:0] mod_n;
  logic       reset_req;

  rk_kbd_matrix #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code       (code),
    .col_n      (col_n),
    .row_n      (row_n),
    .mod_n      (mod_n),
    .reset_req  (reset_req)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic [7:0] row;
    logic [2:0] mod;
    logic       rreq;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: prefix flags, pressed-key table, keymap dictionary.
  bit         m_keys [8][8];
  bit   [2:0] m_mods;
  bit         m_ext, m_brk, m_rreq;
  int         m_last;
  int         keymap [int];  // (ext*256 + code) -> col*8+row, or 64+modbit
  logic [7:0] pool [29];

  function automatic void add_key(int ext, int c, int col, int row);
    keymap[ext * 256 + c] = col * 8 + row;
  endfunction

  function automatic void add_mod(int ext, int c, int mbit);
    keymap[ext * 256 + c] = 64 + mbit;
  endfunction

  function automatic void map_init();
    add_key(0, 'h1C, 2, 4); add_key(0, 'h5A, 1, 2); add_key(0, 'h29, 7, 7);
    add_key(0, 'h32, 3, 4); add_key(0, 'h21, 4, 4); add_key(0, 'h23, 5, 4);
    add_key(0, 'h24, 6, 4); add_key(0, 'h2B, 7, 4); add_key(0, 'h16, 1, 3);
    add_key(0, 'h1E, 2, 3); add_key(0, 'h26, 3, 3); add_key(0, 'h25, 4, 3);
    add_key(0, 'h66, 2, 1); add_key(0, 'h76, 0, 0); add_key(0, 'h0D, 1, 0);
    add_key(0, 'h05, 2, 0);
    add_key(1, 'h75, 0, 5); add_key(1, 'h72, 0, 6); add_key(1, 'h6B, 0, 7);
    add_key(1, 'h74, 0, 4);
    add_mod(0, 'h12, 0); add_mod(0, 'h59, 0); add_mod(0, 'h14, 1);
    add_mod(1, 'h14, 1); add_mod(0, 'h58, 2);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++) m_keys[c][r] = 1'b0;
    m_mods = '0; m_ext = 0; m_brk = 0; m_rreq = 0; m_last = 0;
  endfunction

  function automatic void model_byte(logic [7:0] b, int edge_no);
    int key, v;
    if ((m_ext || m_brk) && (edge_no - m_last > int'(TO))) begin
      m_ext = 0; m_brk = 0;
    end
    m_last = edge_no;
    m_rreq = 0;
    if (b == 8'hE0) begin
      if (!m_brk) m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (!m_ext && !m_brk && (b == 8'hAA || b == 8'hFC)) begin
        for (int c = 0; c < 8; c++)
          for (int r = 0; r < 8; r++) m_keys[c][r] = 1'b0;
        m_mods = '0;
      end else begin
        key = (m_ext ? 256 : 0) + int'(b);
        if (keymap.exists(key)) begin
          v = keymap[key];
          if (v >= 64) m_mods[v-64] = !m_brk;
          else m_keys[v/8][v%8] = !m_brk;
        end
        if (!m_ext && !m_brk && b == 8'h07) m_rreq = 1;
      end
      m_ext = 0; m_brk = 0;
    end
  endfunction

  function automatic logic [7:0] model_row(logic [7:0] col);
    logic [7:0] r = 8'hFF;
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 8; k++)
        if (!col[c] && m_keys[c][k]) r[k] = 1'b0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    m_rreq = 0;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic send(logic [7:0] b);
    code       = b;
    code_valid = 1'b1;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    model_byte(b, cyc);
  endtask

  task automatic push(string name, logic [7:0] row, logic [2:0] mod, logic rreq);
    exp_t e;
    e.name = name; e.row = row; e.mod = mod; e.rreq = rreq;
    sb.push_back(e);
  endtask

  // Expectation from the reference model.
  task automatic chk_model(logic [7:0] col);
    col_n = col;
    push("random", model_row(col), ~m_mods, m_rreq);
    tick();
  endtask

  // Expectation given as constants.
  task automatic chk(string name, logic [7:0] col, logic [7:0] row, logic [2:0] mod,
                     logic rreq);
    col_n = col;
    push(name, row, mod, rreq);
    tick();
  endtask

  task automatic do_reset();
    code_valid = 1'b0;
    reset      = 1'b1;
    col_n      = 8'h00;
    model_reset();
    #1;
    push("reset", 8'hFF, 3'b111, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic cmp(string name, string field, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s.%s: got %h expected %h (t=%0t)", name, field, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the oldest pending expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        cmp(e.name, "row_n", row_n, e.row);
        cmp(e.name, "mod_n", {5'b0, mod_n}, {5'b0, e.mod});
        cmp(e.name, "reset_req", {7'b0, reset_req}, {7'b0, e.rreq});
      end
    end
  end

  initial begin
    logic [7:0] b;
    int         r;
    pool = '{8'h1C, 8'h5A, 8'h29, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h16, 8'h1E,
             8'h26, 8'h25, 8'h66, 8'h76, 8'h0D, 8'h05, 8'h75, 8'h72, 8'h6B, 8'h74,
             8'h12, 8'h59, 8'h14, 8'h58, 8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'h33};
    map_init();
    code_valid = 1'b0;
    code       = 8'h00;
    col_n      = 8'hFF;
    reset      = 1'b1;
    do_reset();

    send(8'h1C);
    chk("a_make", 8'hFB, 8'hEF, 3'b111, 1'b0);
    chk("a_other_col", 8'hFE, 8'hFF, 3'b111, 1'b0);
    send(8'hF0); send(8'h1C);
    chk("a_break", 8'hFB, 8'hFF, 3'b111, 1'b0);

    send(8'hE0); send(8'h75);
    chk("up_make", 8'hFE, 8'hDF, 3'b111, 1'b0);
    send(8'h75);
    chk("plain_75_miss", 8'hFE, 8'hDF, 3'b111, 1'b0);

    send(8'h12); send(8'h14);
    chk("shift_ctrl", 8'hFF, 8'hFF, 3'b100, 1'b0);
    send(8'hF0); send(8'h12);
    chk("shift_break", 8'hFF, 8'hFF, 3'b101, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h14);
    chk("rctrl_break", 8'hFF, 8'hFF, 3'b111, 1'b0);

    send(8'h1C); send(8'h5A);
    chk("a_enter", 8'hF9, 8'hEB, 3'b111, 1'b0);
    send(8'hAA);
    chk("bat_clear", 8'h00, 8'hFF, 3'b111, 1'b0);

    send(8'hF0); idle(20); send(8'h1C);
    chk("prefix_timeout", 8'hFB, 8'hEF, 3'b111, 1'b0);
    // Byte exactly TIMEOUT cycles after F0 still sees the prefix.
    send(8'hF0); idle(TO - 1); send(8'h1C);
    chk("timeout_edge_kept", 8'hFB, 8'hFF, 3'b111, 1'b0);
    send(8'hF0); idle(TO); send(8'h1C);
    chk("timeout_edge_dropped", 8'hFB, 8'hEF, 3'b111, 1'b0);

    send(8'h07);
    chk("f12_pulse", 8'hFF, 8'hFF, 3'b111, 1'b1);
    chk("f12_pulse_end", 8'hFF, 8'hFF, 3'b111, 1'b0);
    send(8'hF0); send(8'h07);
    chk("f12_break", 8'hFF, 8'hFF, 3'b111, 1'b0);

    send(8'hE0);
    do_reset();
    send(8'h75);
    chk("reset_drops_ext", 8'hFE, 8'hFF, 3'b111, 1'b0);

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) b = 8'hE0;
      else if (r < 4) b = 8'hF0;
      else b = pool[$urandom_range(0, 28)];
      send(b);
      repeat ($urandom_range(0, 2)) chk_model(8'($urandom));
      if ($urandom_range(0, 19) == 0) idle(int'($urandom_range(TO - 2, TO + 3)));
    end
    chk_model(8'h00);

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rk_kbd_matrix.md
# rk_kbd_matrix

Keyboard-side peer of the system's 8255-style parallel port: converts a stream of PS/2 set-2 scan codes into an 8×8 key matrix plus three modifier lines. The CPU scans it through the port: port A output drives `col_n`, port B input reads `row_n`, port C input bits 7:5 read `mod_n`. Sits between the PS/2 byte receiver and the parallel-port block in the machine top level.

## Interface
- `TIMEOUT`, default 2_000_000: clk cycles after which a pending E0/F0 prefix is discarded.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high; clock `clk`.
- `code_valid` in 1: one-cycle strobe, `code` is a new scan-code byte.
- `code` in 8: PS/2 set-2 byte.
- `col_n` in 8: column select, active-low, from port A output; several columns may be low at once.
- `row_n` out 8: row sense, active-low, to port B input.
- `mod_n` out 3: active-low modifiers to port C input [7:5]; bit2 RUS/LAT, bit1 CTRL, bit0 SHIFT.
- `reset_req` out 1: one-cycle pulse on F12 make (code 0x07), for machine warm reset.

## Operation
- State: `keys[8][8]` (column×row, 1 = pressed), `mods[2:0]`, decoder FSM.
- FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXTBRK (E0 F0 seen).
  - IDLE: 0xF0→BRK; 0xE0→EXT; other → make of normal code, stay IDLE.
  - EXT: 0xF0→EXTBRK; 0xE0→stay EXT; other → make of extended code, →IDLE.
  - BRK: 0xE0/0xF0→stay BRK (ignored); other → break of normal code, →IDLE.
  - EXTBRK: 0xE0/0xF0→stay; other → break of extended code, →IDLE.
- Prefix timeout: counter restarts on every accepted byte; in a non-IDLE state, reaching TIMEOUT cycles with no `code_valid` → IDLE, no matrix change.
- Lookup: {ext, code} → {hit, is_mod, col[2:0], row[2:0]} via keymap. Make sets, break clears the addressed `keys` bit or `mods` bit. Miss: FSM advances, no state change.
- Fixed map entries (the full table is in the package): 0x1C A→col 2,row 4; 0x5A Enter→col 1,row 2; 0x29 Space→col 7,row 7; E0 0x75 Up→col 0,row 5; 0x12 and 0x59 L/R Shift→mod bit0; 0x14 Ctrl→mod bit1; E0 0x14 R-Ctrl→mod bit1; 0x58 CapsLock→mod bit2.
- Special: 0xAA (BAT OK) or 0xFC (BAT fail) in IDLE clears all keys and mods. 0xE1 is unmapped (Pause sequence bytes produce misses only). F12 make asserts `reset_req`; F12 break does nothing.
- Outputs (combinational from registers and `col_n`): `row_n[r]` = ~OR over c with col_n[c]==0 of keys[c][r]; `mod_n` = ~mods. Ghosting is not suppressed.
- Repeated make of a held key: no change. Break of an unpressed key: no change.

## Timing
- Reset: FSM IDLE, keys and mods all 0, timeout counter 0; `row_n`=0xFF, `mod_n`=3'b111, `reset_req`=0.
- `code_valid` at edge N: FSM and matrix updated at edge N (visible after it); `reset_req` high for the cycle following edge N.
- `col_n`→`row_n`: combinational, zero cycles; the port samples it on CPU read.
- `code_valid` is at most once per cycle; no backpressure; every byte is accepted.
- Reset mid-sequence (for example after E0) returns to IDLE; the next byte is decoded as unprefixed.

## Structure
- Package `rk_kbd_pkg`: FSM state enum, modifier bit indices, special codes (F0, E0, AA, FC, 07), keymap entry type and table constant.
- Sub-module `rk_keymap`: combinational {ext, code} → entry lookup; keeps the decoder free of the table.

## Test plan
- Reset, `col_n`=0x00 → `row_n`=0xFF, `mod_n`=3'b111.
- Bytes 1C; `col_n`=0xFB → `row_n`=0xEF. `col_n`=0xFE → `row_n`=0xFF. Then F0 1C → `row_n`=0xFF with col 2 selected.
- E0 75, `col_n`=0xFE → `row_n`=0xDF. Then 75 (no E0), `col_n`=0xFE → unchanged (0xDF; 0x75 unmapped).
- 12 then 14 → `mod_n`=3'b100. F0 12 → 3'b101. E0 F0 14 → 3'b111.
- Press A and Enter, `col_n`=0xF9 → `row_n`=0xEB. Then AA → `row_n`=0xFF.
- TIMEOUT=16: F0, 20 idle cycles, 1C → A pressed (prefix dropped). Separately, 07 → `reset_req` high for exactly 1 cycle.
